fetch_unit: RTL and testbench

Instruction fetch stage feeding the main controller. Holds the PC, issues single-outstanding requests to instruction memory over a req/ack handshake, and presents the fetched word with its `op`/`funct` fields to the controller and datapath under a valid/ready handshake. On each accept it selects the next PC from the controller's `jump`/`pcsrc` outputs, closing the loop between decode and fetch.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_unit_pc_next.sv | 32 +++
 rtl/fetch_unit.sv | 75 +++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int JADDR_MSB = 25;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: jump beats branch, branch beats sequential.
module pc_next
   import fetch_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0]         pcplus4,
   input  logic [JADDR_MSB:0]   jaddr,
   input  logic [N-1:0]         signimm,
   input  logic                 jump,
   input  logic                 pcsrc,
   output logic [N-1:0]         pc_nxt
);

   logic [N-1:0] boff;
   logic [N-1:0] pc_branch;
   logic [N-1:0] pc_jump;

   // Word offset to byte offset; the top two offset bits fall off, which is the wrap the ISA expects.
   assign boff      = signimm << 2;
   assign pc_branch = pcplus4 + boff;
   assign pc_jump   = {pcplus4[31:28], jaddr, 2'b00};

   always_comb begin
      pc_nxt = pcplus4;
      if (jump)
         pc_nxt = pc_jump;
      else if (pcsrc)
         pc_nxt = pc_branch;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request, valid/ready instruction output.
//
//   state | meaning
//   IDLE  | one cycle after reset, no request
//   FETCH | imem_req high at pc, waiting for imem_ack
//   HOLD  | instr valid, waiting for instr_ready to advance pc
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          N        = 32,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pcsrc,
   input  logic          jump,
   input  logic [N-1:0]  signimm,
   output logic          imem_req,
   output logic [N-1:0]  imem_addr,
   input  logic          imem_ack,
   input  logic [31:0]   imem_rdata,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [31:0]   instr,
   output logic [5:0]    op,
   output logic [5:0]    funct,
   output logic [N-1:0]  pc,
   output logic [N-1:0]  pcplus4
);

   fetch_state_t state;
   logic [N-1:0] pc_nxt;

   assign pcplus4     = pc + N'(4);
   assign imem_req    = (state == FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == HOLD);
   assign op          = instr[OP_MSB:OP_LSB];
   assign funct       = instr[FUNCT_MSB:0];

   pc_next #(.N(N)) u_pc_next (
      .pcplus4 (pcplus4),
      .jaddr   (instr[JADDR_MSB:0]),
      .signimm (signimm),
      .jump    (jump),
      .pcsrc   (pcsrc),
      .pc_nxt  (pc_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         case (state)
            IDLE:  state <= FETCH;
            FETCH: begin
               if (imem_ack) begin
                  instr <= imem_rdata;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  pc    <= pc_nxt;
                  state <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch, jump priority, stalls, wrap and reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcsrc, jump;
   logic [31:0] signimm;
   logic        imem_req, imem_ack, instr_valid, instr_ready;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4;
   logic [5:0]  op, funct;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc, w_pcplus4;
   logic [5:0]  w_op, w_funct;

   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[9:2]];

   fetch_unit dut (
      .clk(clk), .reset(reset), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .op(op), .funct(funct), .pc(pc), .pcplus4(pcplus4)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset(reset), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(w_valid), .instr_ready(instr_ready), .instr(w_instr),
      .op(w_op), .funct(w_funct), .pc(w_pc), .pcplus4(w_pcplus4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]  = 32'h0000_0020;
      mem[1]  = 32'h8C08_0004;
      mem[2]  = 32'h0800_0004;   // j 0x10
      mem[4]  = 32'h1000_FFFE;   // beq back to 0x0C
      mem[3]  = 32'h0800_0008;   // j 0x20
      mem[8]  = 32'h0800_0040;   // j 0x100
      mem[64] = 32'hABCD_EF12;
      mem[65] = 32'h1234_5678;

      reset = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1;
      jump = 1'b0; pcsrc = 1'b0; signimm = 32'h0;

      step(); step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);
      reset = 1'b0;

      // sequential fetch, one instruction per two cycles
      step();
      chk("seq_req0", {31'b0, imem_req}, 32'd1);
      chk("seq_addr0", imem_addr, 32'h0);
      chk("seq_valid0", {31'b0, instr_valid}, 32'd0);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      step();
      chk("seq_valid1", {31'b0, instr_valid}, 32'd1);
      chk("seq_req1", {31'b0, imem_req}, 32'd0);
      chk("seq_op0", {26'b0, op}, 32'h00);
      chk("seq_funct0", {26'b0, funct}, 32'h20);
      step();
      chk("seq_addr1", imem_addr, 32'h4);
      chk("seq_valid2", {31'b0, instr_valid}, 32'd0);
      chk("wrap_addr1", w_addr, 32'h0);
      step();
      chk("seq_valid3", {31'b0, instr_valid}, 32'd1);
      chk("seq_op1", {26'b0, op}, 32'h23);
      chk("seq_funct1", {26'b0, funct}, 32'h04);
      step();
      chk("seq_addr2", imem_addr, 32'h8);

      step();
      chk("j1_instr", instr, 32'h0800_0004);
      jump = 1'b1;
      step();
      jump = 1'b0;
      chk("j1_addr", imem_addr, 32'h10);

      step();
      pcsrc = 1'b1; signimm = 32'hFFFF_FFFE;
      step();
      pcsrc = 1'b0; signimm = 32'h0;
      chk("br_addr", imem_addr, 32'h0C);

      step();
      jump = 1'b1;
      step();
      jump = 1'b0;
      chk("j2_addr", imem_addr, 32'h20);

      step();
      chk("jp_instr", instr, 32'h0800_0040);
      jump = 1'b1; pcsrc = 1'b1; signimm = 32'h0000_0010;
      step();
      jump = 1'b0; pcsrc = 1'b0; signimm = 32'h0;
      chk("jp_addr", imem_addr, 32'h100);

      // memory stall then downstream stall
      imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mst_req", {31'b0, imem_req}, 32'd1);
         chk("mst_addr", imem_addr, 32'h100);
         chk("mst_valid", {31'b0, instr_valid}, 32'd0);
      end
      imem_ack = 1'b1; instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("dst_valid", {31'b0, instr_valid}, 32'd1);
         chk("dst_instr", instr, 32'hABCD_EF12);
         chk("dst_op", {26'b0, op}, 32'h2A);
         chk("dst_funct", {26'b0, funct}, 32'h12);
         chk("dst_pc", pc, 32'h100);
      end
      instr_ready = 1'b1; imem_ack = 1'b0;
      step();
      chk("stl_next_addr", imem_addr, 32'h104);
      chk("stl_next_req", {31'b0, imem_req}, 32'd1);
      step();
      chk("early_rdy_addr", imem_addr, 32'h104);
      chk("early_rdy_valid", {31'b0, instr_valid}, 32'd0);

      // reset wins over a same-cycle ack
      imem_ack = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_pc", pc, 32'h0);
      chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
      chk("mrst_instr", instr, 32'h0);
      chk("mrst_req", {31'b0, imem_req}, 32'd0);
      step();
      chk("idle_ack_instr", instr, 32'h0);
      chk("idle_ack_valid", {31'b0, instr_valid}, 32'd0);
      chk("idle_ack_req", {31'b0, imem_req}, 32'd1);
      step();
      chk("post_rst_valid", {31'b0, instr_valid}, 32'd1);
      chk("post_rst_instr", instr, 32'h0000_0020);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
